fan_pwm_driver: RTL and testbench
=================================

// Module: fan_pwm_driver
// PURPOSE
//  Consumer end of the fan-mode interface: takes the 3-bit fan state from the mode FSM
//  and drives the fan motor with a glitch-free PWM waveform plus a one-hot mode LED bar.
//  Sits between the mode FSM and the board motor-driver pin.
//  Duty changes take effect only at PWM period boundaries.
// PARAMETERS
//  PRESCALE  1000  clk cycles per PWM tick (100 MHz -> 100 kHz tick); must be >= 1
//  PWM_MAX   100   ticks per PWM period (period = PRESCALE*PWM_MAX clks); 2..255
//  DUTY_1    40    duty, in ticks, for fan state 1; must be <= PWM_MAX
//  DUTY_2    70    duty, in ticks, for fan state 2; must be <= PWM_MAX
//  DUTY_3    100   duty, in ticks, for fan state 3; must be <= PWM_MAX
//  RAMP_STEP 10    soft-start duty increment per period (only with macro)
// PORTS
//  i_clk       in   1  system clock
//  i_reset     in   1  asynchronous active-high reset
//  i_fanState  in   3  fan state from mode FSM: 0=off, 1..3=speed; 4..7 treated as 0
//  o_pwm       out  1  motor PWM, registered
//  o_duty      out  8  duty currently applied, in ticks
//  o_ledMode   out  4  one-hot applied-mode indicator: bit n = state n
//  o_ramping   out  1  high while applied duty < target duty in S_RAMP
// BEHAVIOUR
//  - Reset (async, i_reset=1): all outputs 0, except o_ledMode=4'b0001.
//    Prescaler, period counter and duty cleared; FSM in S_OFF.
//  - Ticking: tick pulses 1 clk every PRESCALE clks.
//    r_pwmCnt advances on each tick and counts 0..PWM_MAX-1, then wraps.
//  - End of period: tick && r_pwmCnt==PWM_MAX-1.
//  - Target: i_fanState is sampled every clk into r_target through the duty table
//    (0 -> 0, 1 -> DUTY_1, 2 -> DUTY_2, 3 -> DUTY_3, 4..7 -> 0).
//  - o_pwm = registered (r_pwmCnt < r_dutyCur), so 1 clk latency vs. the counter.
//    Duty 0 gives constant low; duty PWM_MAX gives constant high. No runt pulses.
//  - FSM states:
//    S_OFF:  duty 0. Target != 0 at end of period -> S_RAMP (macro) or S_RUN (no macro).
//    S_RAMP: at each end of period, dutyCur = min(dutyCur+RAMP_STEP, target);
//            go to S_RUN when dutyCur reaches target.
//            Target 0 -> S_OFF with duty 0 at the next end of period.
//    S_RUN:  at end of period, dutyCur = target.
//            Target 0 -> S_OFF. Target > dutyCur -> S_RAMP (macro) or load directly.
//            Target < dutyCur -> load directly (decrease is never ramped).
//  - Mode changes: several changes within one period; only the value sampled at end of
//    period counts. Duty and LED update together in the same clk at end of period.
//  - o_ledMode reflects the applied mode, not the requested one.
//  - Reset mid-period: o_pwm drops asynchronously; counting restarts from 0 after release.
//  - Arithmetic: duty fields 8 bits wide. Ramp add is saturated at target, no overflow.
// CONFIGURATION
//  FAN_SOFTSTART_EN defined: S_RAMP exists and increases ramp by RAMP_STEP per period;
//    o_ramping is high in S_RAMP.
//  Not defined: S_RAMP is not built, target is loaded at the next end of period,
//    and o_ramping is tied 0.
// STRUCTURE
//  Package fan_pkg: fan state codes FAN_0..FAN_3 (shared with the mode FSM),
//    FSM state encoding S_OFF/S_RAMP/S_RUN, default duty constants.
//  Sub-module fan_pwm_tick: PRESCALE divider producing the 1-clk tick.
// TESTING (sim params: PRESCALE=2, PWM_MAX=10, DUTY_1=3, DUTY_2=6, DUTY_3=10, RAMP_STEP=4)
//  1. Reset, fanState=0 for 3 periods -> o_pwm=0, o_duty=0, o_ledMode=0001.
//  2. fanState=1 mid-period, no macro -> duty 3 from next period (high 6 clk of 20);
//     o_ledMode=0010.
//  3. fanState=3, no macro -> o_pwm constant 1, o_duty=10, no low glitch at wrap.
//  4. Macro on, 0 -> 3 -> o_duty 4, 8, 10 over successive periods; o_ramping high for
//     3 periods, then low.
//  5. fanState 2 -> 5 -> treated as off: o_duty=0 at next end of period, o_ledMode=0001.
//  6. i_reset pulse mid-period in S_RUN duty 6 -> o_pwm=0 immediately, counters cleared,
//     then restart as in test 1.

Source files
------------

// File: rtl/fan_pkg.sv
// Shared definitions for the fan-mode interface.
//  - FAN_0..FAN_3: fan state codes exchanged with the mode FSM (0 = off, 1..3 = speed).
//  - fan_fsm_e: driver FSM state encoding (S_OFF / S_RAMP / S_RUN).
//  - DEF_*: default timing and duty constants for fan_pwm_driver.
//  - mode_onehot(): applied mode to one-hot LED bar.
package fan_pkg;

  localparam logic [2:0] FAN_0 = 3'd0;
  localparam logic [2:0] FAN_1 = 3'd1;
  localparam logic [2:0] FAN_2 = 3'd2;
  localparam logic [2:0] FAN_3 = 3'd3;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RAMP = 2'd1,
    S_RUN  = 2'd2
  } fan_fsm_e;

  localparam int unsigned DEF_PRESCALE  = 1000;
  localparam int unsigned DEF_PWM_MAX   = 100;
  localparam int unsigned DEF_DUTY_1    = 40;
  localparam int unsigned DEF_DUTY_2    = 70;
  localparam int unsigned DEF_DUTY_3    = 100;
  localparam int unsigned DEF_RAMP_STEP = 10;

  function automatic logic [3:0] mode_onehot(input logic [1:0] mode);
    return 4'b0001 << mode;
  endfunction

endpackage

// File: rtl/fan_pwm_tick.sv
// PWM tick prescaler: o_tick pulses high for one clock every PRESCALE clocks.
// Ports:
//  i_clk    system clock
//  i_reset  asynchronous active-high reset (divider restarts from 0)
//  o_tick   1-clk tick strobe
module fan_pwm_tick #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = (cnt_q == CntW'(PRESCALE - 1));
    cnt_d  = o_tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fan_pwm_driver.sv
// Fan motor PWM driver: maps the 3-bit fan state from the mode FSM onto a duty table and
// drives a glitch-free registered PWM plus a one-hot LED bar of the applied mode.
// Duty and LED only change at PWM period boundaries.
// Optional feature: define FAN_SOFTSTART_EN to build the S_RAMP soft-start state, which
// raises the duty by RAMP_STEP per period; otherwise targets load at the next boundary.
// Ports:
//  i_clk        system clock
//  i_reset      asynchronous active-high reset
//  i_fanState   requested fan state (0 off, 1..3 speed, 4..7 treated as off)
//  o_pwm        registered motor PWM
//  o_duty       applied duty in ticks
//  o_ledMode    one-hot applied mode (bit n = state n)
//  o_ramping    high while soft-starting below target (0 without FAN_SOFTSTART_EN)
module fan_pwm_driver
  import fan_pkg::*;
#(
  parameter int unsigned PRESCALE  = DEF_PRESCALE,
  parameter int unsigned PWM_MAX   = DEF_PWM_MAX,
  parameter int unsigned DUTY_1    = DEF_DUTY_1,
  parameter int unsigned DUTY_2    = DEF_DUTY_2,
  parameter int unsigned DUTY_3    = DEF_DUTY_3,
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_fanState,
  output logic       o_pwm,
  output logic [7:0] o_duty,
  output logic [3:0] o_ledMode,
  output logic       o_ramping
);

  // Elaboration-time parameter sanity checks.
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be >= 1");
  end
  if (PWM_MAX < 2 || PWM_MAX > 255) begin : g_bad_pwm_max
    $error("PWM_MAX must be in 2..255");
  end
  if (DUTY_1 > PWM_MAX || DUTY_2 > PWM_MAX || DUTY_3 > PWM_MAX) begin : g_bad_duty
    $error("DUTY_n must be <= PWM_MAX");
  end
  if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_bad_ramp_step
    $error("RAMP_STEP must be in 1..255");
  end

  logic       tick;
  logic       end_of_period;
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0] target_q, target_d;
  logic [1:0] tgt_mode_q, tgt_mode_d;
  logic [7:0] duty_q, duty_d;
  logic [1:0] mode_q, mode_d;
  logic       pwm_q;
  fan_fsm_e   state_q, state_d;

  fan_pwm_tick #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .o_tick (tick)
  );

  always_comb begin
    end_of_period = tick && (pwm_cnt_q == 8'(PWM_MAX - 1));
    pwm_cnt_d     = pwm_cnt_q;
    if (tick) begin
      pwm_cnt_d = end_of_period ? 8'd0 : pwm_cnt_q + 8'd1;
    end
  end

  // Duty table; undefined states 4..7 request off.
  always_comb begin
    target_d   = 8'd0;
    tgt_mode_d = 2'd0;
    case (i_fanState)
      FAN_1: begin
        target_d   = 8'(DUTY_1);
        tgt_mode_d = 2'd1;
      end
      FAN_2: begin
        target_d   = 8'(DUTY_2);
        tgt_mode_d = 2'd2;
      end
      FAN_3: begin
        target_d   = 8'(DUTY_3);
        tgt_mode_d = 2'd3;
      end
      default: begin
        target_d   = 8'd0;
        tgt_mode_d = 2'd0;
      end
    endcase
  end

`ifdef FAN_SOFTSTART_EN
  logic [8:0] ramp_sum;
  logic [7:0] ramp_next;

  // 9-bit add so the step never wraps before saturating at target.
  always_comb begin
    ramp_sum  = {1'b0, duty_q} + 9'(RAMP_STEP);
    ramp_next = (ramp_sum >= {1'b0, target_q}) ? target_q : ramp_sum[7:0];
  end
`endif

  // State register (FSM, duty, applied mode, counter, PWM output flop).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_OFF;
      duty_q     <= 8'd0;
      mode_q     <= 2'd0;
      pwm_cnt_q  <= 8'd0;
      target_q   <= 8'd0;
      tgt_mode_q <= 2'd0;
      pwm_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      mode_q     <= mode_d;
      pwm_cnt_q  <= pwm_cnt_d;
      target_q   <= target_d;
      tgt_mode_q <= tgt_mode_d;
      pwm_q      <= (pwm_cnt_q < duty_q);
    end
  end

  // Next state: everything moves only at the period boundary, so duty and LED change
  // together and the PWM never sees a mid-period duty change.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    mode_d  = mode_q;
    if (end_of_period) begin
      mode_d = tgt_mode_q;
      case (state_q)
        S_OFF: begin
          if (target_q != 8'd0) begin
`ifdef FAN_SOFTSTART_EN
            state_d = S_RAMP;
`else
            state_d = S_RUN;
            duty_d  = target_q;
`endif
          end
        end
`ifdef FAN_SOFTSTART_EN
        S_RAMP: begin
          if (target_q == 8'd0) begin
            state_d = S_OFF;
            duty_d  = 8'd0;
          end else begin
            duty_d = ramp_next;
            if (ramp_next == target_q) begin
              state_d = S_RUN;
            end
          end
        end
`endif
        S_RUN: begin
          if (target_q == 8'd0) begin
            state_d = S_OFF;
            duty_d  = 8'd0;
`ifdef FAN_SOFTSTART_EN
          end else if (target_q > duty_q) begin
            state_d = S_RAMP;
`endif
          end else begin
            duty_d = target_q;
          end
        end
        default: begin
          state_d = S_OFF;
          duty_d  = 8'd0;
        end
      endcase
    end
  end

  always_comb begin
    o_pwm     = pwm_q;
    o_duty    = duty_q;
    o_ledMode = mode_onehot(mode_q);
`ifdef FAN_SOFTSTART_EN
    o_ramping = (state_q == S_RAMP) && (duty_q < target_q);
`else
    o_ramping = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fan_pwm_driver.sv
// Scoreboard bench for fan_pwm_driver. Stimulus drives fan states per PWM period and
// pushes the expected applied duty/LED/ramping for the following period; the monitor
// pops at each period boundary and checks the PWM waveform every clock.
module tb_fan_pwm_driver;

  localparam int P   = 2;
  localparam int M   = 10;
  localparam int D1  = 3;
  localparam int D2  = 6;
  localparam int D3  = 10;
  localparam int RS  = 4;
  localparam int PER = P * M;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] fan = 3'd0;
  logic       o_pwm;
  logic [7:0] o_duty;
  logic [3:0] o_ledMode;
  logic       o_ramping;

  typedef struct {
    int duty;
    int led;
    int ramping;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: phase 0 = off, 1 = soft-starting, 2 = running.
  int   m_duty  = 0;
  int   m_phase = 0;

  always #5 clk = ~clk;

  fan_pwm_driver #(
    .PRESCALE (P),
    .PWM_MAX  (M),
    .DUTY_1   (D1),
    .DUTY_2   (D2),
    .DUTY_3   (D3),
    .RAMP_STEP(RS)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_fanState(fan),
    .o_pwm     (o_pwm),
    .o_duty    (o_duty),
    .o_ledMode (o_ledMode),
    .o_ramping (o_ramping)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int duty_of(input int f);
    case (f)
      1: return D1;
      2: return D2;
      3: return D3;
      default: return 0;
    endcase
  endfunction

  // Applies one period-boundary decision for the fan state f that was held at the boundary.
  task automatic model_step(input int f, output exp_t e);
    int tgt;
    int mode;
    tgt  = duty_of(f);
    mode = (f <= 3) ? f : 0;
`ifdef FAN_SOFTSTART_EN
    if (tgt == 0) begin
      m_phase = 0;
      m_duty  = 0;
    end else if (m_phase == 1) begin
      m_duty = (m_duty + RS >= tgt) ? tgt : m_duty + RS;
      if (m_duty == tgt) m_phase = 2;
    end else if (m_phase == 0 || tgt > m_duty) begin
      m_phase = 1;
    end else begin
      m_duty = tgt;
    end
    e.ramping = (m_phase == 1 && m_duty < tgt) ? 1 : 0;
`else
    m_duty    = tgt;
    m_phase   = (tgt == 0) ? 0 : 2;
    e.ramping = 0;
`endif
    e.duty = m_duty;
    e.led  = 1 << mode;
  endtask

  // Called at position 0 of a period (a negedge); returns at position 0 of the next.
  // Intra-period changes are kept clear of the boundary so only f_final counts.
  task automatic run_period(input int f_final, input bit scramble);
    exp_t e;
    for (int pos = 0; pos < PER; pos++) begin
      if (scramble && pos >= 2 && pos < PER - 5 && $urandom_range(0, 3) == 0) begin
        fan = 3'($urandom_range(0, 7));
      end
      if (pos == PER - 5) fan = 3'(f_final);
      if (pos == PER - 1) begin
        model_step(f_final, e);
        sb_q.push_back(e);
      end
      @(negedge clk);
    end
  endtask

  // Monitor: cyc counts rising edges since reset release.
  initial begin
    int   cyc;
    int   cur_duty;
    int   cur_led;
    int   exp_pwm;
    exp_t e;
    cyc      = 0;
    cur_duty = 0;
    cur_led  = 1;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cyc      = 0;
        cur_duty = 0;
        cur_led  = 1;
      end else begin
        cyc++;
        // PWM after edge n reflects counter and duty just before that edge.
        exp_pwm = ((((cyc - 1) / P) % M) < cur_duty) ? 1 : 0;
        check("pwm", int'(o_pwm), exp_pwm);
        if (cyc % PER == 0) begin
          if (sb_q.size() == 0) begin
            check("sb_empty", 0, 1);
          end else begin
            e = sb_q.pop_front();
            check("duty_boundary", int'(o_duty), e.duty);
            check("led_boundary", int'(o_ledMode), e.led);
            check("ramping_boundary", int'(o_ramping), e.ramping);
            cur_duty = e.duty;
            cur_led  = e.led;
          end
        end
        check("duty_hold", int'(o_duty), cur_duty);
        check("led_hold", int'(o_ledMode), cur_led);
      end
    end
  end

  initial begin
    rst = 1'b1;
    fan = 3'd0;
    repeat (3) @(negedge clk);
    check("reset_pwm", int'(o_pwm), 0);
    check("reset_duty", int'(o_duty), 0);
    check("reset_led", int'(o_ledMode), 1);
    check("reset_ramping", int'(o_ramping), 0);
    rst = 1'b0;

    repeat (3) run_period(0, 1'b0);
    repeat (3) run_period(1, 1'b1);
    repeat (3) run_period(3, 1'b0);
    repeat (4) run_period(2, 1'b0);
    repeat (2) run_period(5, 1'b0);
    run_period(0, 1'b0);
    repeat (5) run_period(3, 1'b0);
    repeat (40) run_period(int'($urandom_range(0, 7)), 1'b1);
    repeat (4) run_period(2, 1'b0);

    // Reset pulse mid-period while running at duty 6.
    repeat (3) @(negedge clk);
    check("pwm_pre_reset", int'(o_pwm), (1 < m_duty) ? 1 : 0);
    #3;
    rst = 1'b1;
    fan = 3'd0;
    #1;
    check("midreset_pwm", int'(o_pwm), 0);
    check("midreset_duty", int'(o_duty), 0);
    check("midreset_led", int'(o_ledMode), 1);
    check("midreset_ramping", int'(o_ramping), 0);
    @(negedge clk);
    @(negedge clk);
    sb_q.delete();
    m_duty  = 0;
    m_phase = 0;
    rst     = 1'b0;

    repeat (3) run_period(0, 1'b0);
    repeat (10) run_period(int'($urandom_range(0, 7)), 1'b1);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
